// File: rtl/nes_pad_pkg.sv
`default_nettype none
// ============================================================================
// nes_pad_pkg - shared state type and button layout for nes_pad_reader;
// define SNES_PAD_EN for the 16-bit SNES build.  Rev 1.0
// ============================================================================
package nes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        BIT_HI = 3'd2,
        BIT_LO = 3'd3,
        DONE   = 3'd4
    } state_t;

`ifdef SNES_PAD_EN
    localparam int N_BITS = 16;
    localparam int BTN_W  = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_TL     = 10;
    localparam int BTN_TR     = 11;
    localparam int BTN_ID_LSB = 12;
`else
    localparam int N_BITS = 8;
    localparam int BTN_W  = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
`endif

endpackage
`default_nettype wire

// File: rtl/pad_sync.sv
`default_nettype none
// ============================================================================
// pad_sync - 2-FF synchronizer, resets to the idle (pulled-up) line level.
// Rev 1.0
// ============================================================================
module pad_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// nes_pad_reader - latch/clock initiator reading two NES (or SNES with
// SNES_PAD_EN) serial pads into active-high button words.  Rev 1.0
// ============================================================================
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int HALF_DIV = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             poll,
    input  logic             pad_data1,
    input  logic             pad_data2,
    output logic             pad_latch,
    output logic             pad_clk,
    output logic [BTN_W-1:0] buttons1,
    output logic [BTN_W-1:0] buttons2,
    output logic             valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(2 * HALF_DIV);
    localparam int IDX_W = $clog2(N_BITS);

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BITS - 1);

    logic data1_s;
    logic data2_s;

    pad_sync u_sync1 (
        .clk   (clk),
        .reset (reset),
        .d_i   (pad_data1),
        .q_o   (data1_s)
    );

    pad_sync u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d_i   (pad_data2),
        .q_o   (data2_s)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_BITS-1:0]  sh1_q, sh1_d;
    logic [N_BITS-1:0]  sh2_q, sh2_d;
    logic [BTN_W-1:0]   btn1_q, btn1_d;
    logic [BTN_W-1:0]   btn2_q, btn2_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               latch_q;
    logic               pclk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            btn1_q  <= '0;
            btn2_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            btn1_q  <= btn1_d;
            btn2_q  <= btn2_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            // Pad pins are registered from the next state so they switch glitch-free
            // on the same edge as the FSM.
            latch_q <= (state_d == LATCH);
            pclk_q  <= (state_d != BIT_LO);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        btn1_d  = btn1_q;
        btn2_d  = btn2_q;
        busy_d  = busy_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (poll) begin
                    state_d = LATCH;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    sh1_d   = '0;
                    sh2_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = BIT_HI;
                    cnt_d   = '0;
                end
            end
            BIT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    sh1_d[idx_q] = ~data1_s;
                    sh2_d[idx_q] = ~data2_s;
                    cnt_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        // Words and valid are loaded on the edge into DONE so the
                        // DONE cycle presents the new words together with valid.
                        state_d = DONE;
                        valid_d = 1'b1;
                        btn1_d  = sh1_d;
                        btn2_d  = sh2_d;
                    end else begin
                        state_d = BIT_LO;
                    end
                end
            end
            BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = BIT_HI;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pad_latch = latch_q;
    assign pad_clk   = pclk_q;
    assign buttons1  = btn1_q;
    assign buttons2  = btn2_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
// ============================================================================
// tb_nes_pad_reader - table-driven and random scans against a shift-register
// pad model; honours SNES_PAD_EN.  Rev 1.0
// ============================================================================
module tb_nes_pad_reader;

    localparam int H = 4;
`ifdef SNES_PAD_EN
    localparam int NB = 16;
`else
    localparam int NB = 8;
`endif
    localparam logic [15:0] MASK     = (NB == 16) ? 16'hFFFF : 16'h00FF;
    localparam int          SCAN_LEN = 2 * H + NB * H + (NB - 1) * H + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          poll;
    logic          pad_data1;
    logic          pad_data2;
    logic          pad_latch;
    logic          pad_clk;
    logic [NB-1:0] buttons1;
    logic [NB-1:0] buttons2;
    logic          valid;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nes_pad_reader #(.HALF_DIV(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .poll      (poll),
        .pad_data1 (pad_data1),
        .pad_data2 (pad_data2),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons1  (buttons1),
        .buttons2  (buttons2),
        .valid     (valid),
        .busy      (busy)
    );

    // Pad model: latch loads position 0, each pad_clk rise advances one button,
    // pressed buttons drive the line low, an unplugged pad floats high.
    logic [15:0] pbtn1 = '0;
    logic [15:0] pbtn2 = '0;
    logic        pconn1 = 1'b1;
    logic        pconn2 = 1'b1;
    logic [4:0]  ppos = '0;

    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch)
            ppos <= '0;
        else if (!ppos[4])
            ppos <= ppos + 5'd1;
    end

    always_comb begin
        pad_data1 = 1'b1;
        pad_data2 = 1'b1;
        if (pconn1 && !ppos[4]) pad_data1 = ~pbtn1[ppos[3:0]];
        if (pconn2 && !ppos[4]) pad_data2 = ~pbtn2[ppos[3:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [15:0] pressed, input logic conn);
        return conn ? (pressed & MASK) : 16'h0000;
    endfunction

    task automatic run_scan(input logic [15:0] p1, input logic [15:0] p2,
                            input logic c1, input logic c2,
                            input logic [15:0] e1, input logic [15:0] e2,
                            input logic extra_poll);
        int cyc = 0, vcnt = 0, vcyc = -1, rises = 0, lcyc = 0;
        int viol = 0, busyerr = 0, holderr = 0;
        logic prevclk;
        logic [NB-1:0] old1, old2;
        pbtn1 = p1; pbtn2 = p2; pconn1 = c1; pconn2 = c2;
        @(negedge clk);
        old1 = buttons1; old2 = buttons2;
        if (busy !== 1'b0) busyerr++;
        poll = 1'b1;
        prevclk = pad_clk;
        while (cyc < SCAN_LEN + 12) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                vcnt++;
                if (vcyc < 0) vcyc = cyc;
            end
            if (pad_latch) lcyc++;
            if (pad_latch && !pad_clk) viol++;
            if (pad_clk && !prevclk) rises++;
            prevclk = pad_clk;
            if (cyc <= SCAN_LEN && busy !== 1'b1) busyerr++;
            if (cyc > SCAN_LEN && busy !== 1'b0) busyerr++;
            if (vcyc < 0 && (buttons1 !== old1 || buttons2 !== old2)) holderr++;
            if (cyc == SCAN_LEN) begin
                check("buttons1", 32'(buttons1), 32'(e1 & MASK));
                check("buttons2", 32'(buttons2), 32'(e2 & MASK));
            end
            poll = extra_poll && (cyc == 3 || cyc == 20 || cyc == SCAN_LEN);
        end
        poll = 1'b0;
        check("valid_latency", vcyc, SCAN_LEN);
        check("valid_count", vcnt, 1);
        check("clk_rises", rises, NB - 1);
        check("latch_cycles", lcyc, 2 * H);
        check("clk_low_in_latch", viol, 0);
        check("busy_window", busyerr, 0);
        check("hold_until_valid", holderr, 0);
        check("buttons1_after", 32'(buttons1), 32'(e1 & MASK));
    endtask

    typedef struct {
        logic [15:0] p1;
        logic [15:0] p2;
        logic        c1;
        logic        c2;
        logic        extra;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{p1: 16'h0009, p2: 16'h0000, c1: 1'b1, c2: 1'b1, extra: 1'b1, e1: 16'h0009, e2: 16'h0000};
        vecs[1] = '{p1: 16'hFFFF, p2: 16'hFFFF, c1: 1'b0, c2: 1'b0, extra: 1'b0, e1: 16'h0000, e2: 16'h0000};
        vecs[2] = '{p1: 16'hFFFF, p2: 16'hFFFF, c1: 1'b1, c2: 1'b1, extra: 1'b0, e1: 16'hFFFF, e2: 16'hFFFF};
        vecs[3] = '{p1: 16'h0881, p2: 16'h0000, c1: 1'b1, c2: 1'b1, extra: 1'b0, e1: 16'h0881, e2: 16'h0000};
        vecs[4] = '{p1: 16'h3C5A, p2: 16'hC3A5, c1: 1'b1, c2: 1'b1, extra: 1'b1, e1: 16'h3C5A, e2: 16'hC3A5};
        vecs[5] = '{p1: 16'h00FF, p2: 16'h0042, c1: 1'b0, c2: 1'b1, extra: 1'b0, e1: 16'h0000, e2: 16'h0042};

        reset = 1'b1;
        poll  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_latch", 32'(pad_latch), 0);
        check("rst_pad_clk", 32'(pad_clk), 1);
        check("rst_buttons1", 32'(buttons1), 0);
        check("rst_buttons2", 32'(buttons2), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_scan(vecs[i].p1, vecs[i].p2, vecs[i].c1, vecs[i].c2,
                     vecs[i].e1, vecs[i].e2, vecs[i].extra);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] r1, r2;
            logic        k1, k2;
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            k1 = ($urandom_range(3) != 0);
            k2 = ($urandom_range(3) != 0);
            run_scan(r1, r2, k1, k2, ref_word(r1, k1), ref_word(r2, k2), 1'b0);
        end

        // Reset in the low half of bit 3 after a scan has left non-zero words.
        run_scan(16'h00A5, 16'h005A, 1'b1, 1'b1, 16'h00A5, 16'h005A, 1'b0);
        @(negedge clk);
        poll = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            poll = 1'b0;
        end
        check("pre_rst_pad_clk_low", 32'(pad_clk), 0);
        check("pre_rst_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pad_clk", 32'(pad_clk), 1);
        check("mid_rst_latch", 32'(pad_latch), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_buttons1", 32'(buttons1), 0);
        check("mid_rst_buttons2", 32'(buttons2), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_scan(16'h0009, 16'h0006, 1'b1, 1'b1, 16'h0009, 16'h0006, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
